// File: rtl/vrc_pkg.sv
// Shared definitions for the vector response checker.
// Contents: checker FSM state encoding and the settle timer width.
package vrc_pkg;

  // Settle timer width; SETTLE_CYC must fit in 0..15.
  localparam int TMR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/vrc_settle_timer.sv
// Settle-interval down-counter for the vector response checker.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   i_load      : load i_load_val (takes priority over decrement)
//   i_load_val  : value to load
//   i_dec       : decrement by one; holds at zero
//   o_zero      : counter currently reads zero
module vrc_settle_timer
  import vrc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/vector_response_checker.sv
// Receiving end of the combinational-DUT stimulus flow. Each accepted
// vector is held, the DUT output f is sampled SETTLE_CYC+1 edges after the
// handshake and compared with EXP_TABLE[vec]. Vector/mismatch counts
// (saturating) and the first failing vector are kept; done/pass report the
// result once the vector flagged last has been checked.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse, clears statistics and arms (any state)
//   vec_valid/vec/last: vector offer from the source; last marks the final one
//   vec_ready         : checker can accept a vector (ARMED only)
//   f                 : DUT response
//   busy, done, pass  : run in progress / run complete / no mismatches
//   vec_cnt, err_cnt  : vectors checked, mismatches (saturating)
//   first_err_vec/_valid : vector of the first mismatch and its valid flag
module vector_response_checker
  import vrc_pkg::*;
#(
  parameter int                  N_IN       = 4,
  parameter logic [2**N_IN-1:0]  EXP_TABLE  = 16'hA5F0,
  parameter int                  SETTLE_CYC = 2,
  parameter int                  CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [N_IN-1:0]  vec,
  input  logic             last,
  output logic             vec_ready,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  // Timer is loaded with SETTLE_CYC-1 so that SAMPLE falls on edge k+SETTLE_CYC+1.
  localparam logic [TMR_W-1:0] LP_TMR_LOAD =
    (SETTLE_CYC > 0) ? TMR_W'(SETTLE_CYC - 1) : '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IN-1:0]  r_vec_q;
  logic             r_last_q;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [N_IN-1:0]  r_first_err_vec;
  logic             r_first_err_valid;
  logic             w_handshake;
  logic             w_tmr_zero;
  logic             w_mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // start overrides any handshake offered in the same cycle.
  assign w_handshake = (r_state == ST_ARMED) && vec_valid && !start;
  assign w_mismatch  = (f != EXP_TABLE[r_vec_q]);

  vrc_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_handshake),
    .i_load_val (LP_TMR_LOAD),
    .i_dec      (r_state == ST_SETTLE),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARMED:  if (vec_valid) w_state_nxt = (SETTLE_CYC > 0) ? ST_SETTLE : ST_SAMPLE;
      ST_SETTLE: if (w_tmr_zero) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = r_last_q ? ST_DONE : ST_ARMED;
      default:   w_state_nxt = r_state;
    endcase
    if (start) w_state_nxt = ST_ARMED;
  end

  always_comb begin
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_ARMED:  begin vec_ready = 1'b1; busy = 1'b1; end
      ST_SETTLE: busy = 1'b1;
      ST_SAMPLE: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  assign pass = done && (r_err_cnt == '0);

  // Held vector; only read in SAMPLE, which is always preceded by a handshake.
  always_ff @(posedge clk) begin
    if (w_handshake) begin
      r_vec_q  <= vec;
      r_last_q <= last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt         <= '0;
      r_err_cnt         <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (start) begin
      r_vec_cnt         <= '0;
      r_err_cnt         <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (r_state == ST_SAMPLE) begin
      r_vec_cnt <= sat_inc(r_vec_cnt);
      if (w_mismatch) begin
        r_err_cnt <= sat_inc(r_err_cnt);
        if (!r_first_err_valid) begin
          r_first_err_vec   <= r_vec_q;
          r_first_err_valid <= 1'b1;
        end
      end
    end
  end

  assign vec_cnt         = r_vec_cnt;
  assign err_cnt         = r_err_cnt;
  assign first_err_vec   = r_first_err_vec;
  assign first_err_valid = r_first_err_valid;

endmodule
